// File: rtl/placar_bcd.sv
// -----------------------------------------------------------------------------
// placar_bcd -- two-digit BCD score accumulator for one scoreboard team.
//
// Converts debounced +1/+2/+3 button presses, a single-level undo and a clear
// into a saturating 00..99 score. Adds and undos are applied one point per
// clock, so no binary-to-BCD conversion is needed.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_p1    in   add 1 point (level, debounced, synchronous)
//   btn_p2    in   add 2 points
//   btn_p3    in   add 3 points
//   btn_undo  in   remove the points applied by the most recent addition
//   btn_clr   in   clear score to 00 (acts in any state)
//   unidade   out  BCD units digit
//   dezena    out  BCD tens digit
//   busy      out  registered, high while an add/undo sequence runs
//   sat       out  high once an addition has been clipped at 99
// -----------------------------------------------------------------------------
module placar_bcd (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_p1,
   input  logic       btn_p2,
   input  logic       btn_p3,
   input  logic       btn_undo,
   input  logic       btn_clr,
   output logic [3:0] unidade,
   output logic [3:0] dezena,
   output logic       busy,
   output logic       sat
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INC  = 2'd1,
      DEC  = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_pend;
   logic [1:0] r_last;
   logic [3:0] r_uni;
   logic [3:0] r_dez;
   logic       r_busy;
   logic       r_sat;

   // Previous button levels, ordered {clr, undo, p3, p2, p1}. Resetting them
   // to 1 suppresses a phantom event for a button held through reset.
   logic [4:0] r_prev;
   logic [4:0] w_btn;
   logic [4:0] w_ev;

   assign w_btn = {btn_clr, btn_undo, btn_p3, btn_p2, btn_p1};
   assign w_ev  = w_btn & ~r_prev;

   logic w_at99;
   assign w_at99 = (r_uni == 4'd9) && (r_dez == 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pend  <= 2'd0;
         r_last  <= 2'd0;
         r_uni   <= 4'd0;
         r_dez   <= 4'd0;
         r_busy  <= 1'b0;
         r_sat   <= 1'b0;
         r_prev  <= 5'b11111;
      end else begin
         r_prev <= w_btn;
         if (w_ev[4]) begin
            // Clear wins everywhere and aborts any sequence in flight.
            r_state <= IDLE;
            r_pend  <= 2'd0;
            r_last  <= 2'd0;
            r_uni   <= 4'd0;
            r_dez   <= 4'd0;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_ev[3]) begin
                     // Undo with nothing recorded is a no-op.
                     if (r_last != 2'd0) begin
                        r_pend  <= r_last;
                        r_last  <= 2'd0;
                        r_sat   <= 1'b0;
                        r_state <= DEC;
                        r_busy  <= 1'b1;
                     end
                  end else if (w_ev[2]) begin
                     r_pend  <= 2'd3;
                     r_last  <= 2'd0;
                     r_state <= INC;
                     r_busy  <= 1'b1;
                  end else if (w_ev[1]) begin
                     r_pend  <= 2'd2;
                     r_last  <= 2'd0;
                     r_state <= INC;
                     r_busy  <= 1'b1;
                  end else if (w_ev[0]) begin
                     r_pend  <= 2'd1;
                     r_last  <= 2'd0;
                     r_state <= INC;
                     r_busy  <= 1'b1;
                  end
               end
               INC: begin
                  if (w_at99) begin
                     // Clip: remaining points are discarded, last keeps only
                     // what was actually applied.
                     r_sat   <= 1'b1;
                     r_pend  <= 2'd0;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     if (r_uni == 4'd9) begin
                        r_uni <= 4'd0;
                        r_dez <= r_dez + 4'd1;
                     end else begin
                        r_uni <= r_uni + 4'd1;
                     end
                     r_last <= r_last + 2'd1;
                     r_pend <= r_pend - 2'd1;
                     if (r_pend == 2'd1) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               DEC: begin
                  // Undo only removes applied points, so 00 is never crossed.
                  if (r_uni == 4'd0) begin
                     r_uni <= 4'd9;
                     r_dez <= r_dez - 4'd1;
                  end else begin
                     r_uni <= r_uni - 4'd1;
                  end
                  r_pend <= r_pend - 2'd1;
                  if (r_pend == 2'd1) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_pend  <= 2'd0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign unidade = r_uni;
   assign dezena  = r_dez;
   assign busy    = r_busy;
   assign sat     = r_sat;

endmodule

// File: tb/tb_placar_bcd.sv
// -----------------------------------------------------------------------------
// tb_placar_bcd -- directed bench for placar_bcd. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, away from the
// active edge. Button masks are ordered {clr, undo, p3, p2, p1}.
// -----------------------------------------------------------------------------
module tb_placar_bcd;

   logic       clk;
   logic       rst_n;
   logic       btn_p1, btn_p2, btn_p3, btn_undo, btn_clr;
   logic [3:0] unidade, dezena;
   logic       busy, sat;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [4:0] P1   = 5'b00001;
   localparam logic [4:0] P2   = 5'b00010;
   localparam logic [4:0] P3   = 5'b00100;
   localparam logic [4:0] UNDO = 5'b01000;
   localparam logic [4:0] CLR  = 5'b10000;

   placar_bcd dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_p1   (btn_p1),
      .btn_p2   (btn_p2),
      .btn_p3   (btn_p3),
      .btn_undo (btn_undo),
      .btn_clr  (btn_clr),
      .unidade  (unidade),
      .dezena   (dezena),
      .busy     (busy),
      .sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drive(input logic [4:0] m);
      {btn_clr, btn_undo, btn_p3, btn_p2, btn_p1} = m;
   endtask

   // One-cycle pulse; returns just after the edge that samples the event.
   task automatic press(input logic [4:0] m);
      drive(m);
      tick();
      drive(5'b00000);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_score(input string tag, input logic [7:0] exp);
      chk(tag, {dezena, unidade}, exp);
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      chk(tag, {7'd0, obs}, {7'd0, exp});
   endtask

   initial begin
      drive(5'b00000);
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      tick();

      // Reset state
      chk_score("reset score", 8'h00);
      chk_bit("reset busy", busy, 1'b0);
      chk_bit("reset sat", sat, 1'b0);

      // +3 from 00
      press(P3);
      chk_bit("p3 busy k", busy, 1'b1);
      chk_score("p3 k", 8'h00);
      tick(); chk_score("p3 k+1", 8'h01); chk_bit("p3 busy k+1", busy, 1'b1);
      tick(); chk_score("p3 k+2", 8'h02); chk_bit("p3 busy k+2", busy, 1'b1);
      tick(); chk_score("p3 k+3", 8'h03); chk_bit("p3 busy k+3", busy, 1'b0);
      chk_bit("p3 sat", sat, 1'b0);

      // Reach 08, then +3 across the units wrap
      press(P3); run(3);
      press(P2); run(2);
      chk_score("at 08", 8'h08);
      press(P3);
      tick(); chk_score("wrap 09", 8'h09);
      tick(); chk_score("wrap 10", 8'h10);
      tick(); chk_score("wrap 11", 8'h11); chk_bit("wrap busy", busy, 1'b0);

      // Undo back across the wrap, then a second undo does nothing
      press(UNDO);
      chk_bit("undo busy", busy, 1'b1);
      tick(); chk_score("undo 10", 8'h10);
      tick(); chk_score("undo 09", 8'h09);
      tick(); chk_score("undo 08", 8'h08); chk_bit("undo busy end", busy, 1'b0);
      press(UNDO);
      chk_bit("undo2 busy", busy, 1'b0);
      tick(); chk_score("undo2 score", 8'h08);

      // Build up to 98: 08 + 30*3 = 98
      for (int i = 0; i < 30; i++) begin
         press(P3); run(3);
      end
      chk_score("at 98", 8'h98);

      // Saturation mid-add
      press(P3);
      chk_bit("sat busy k", busy, 1'b1);
      tick(); chk_score("sat 99", 8'h99); chk_bit("sat pre", sat, 1'b0);
      chk_bit("sat busy k+1", busy, 1'b1);
      tick(); chk_score("sat hold", 8'h99); chk_bit("sat rise", sat, 1'b1);
      chk_bit("sat busy fall", busy, 1'b0);
      press(UNDO);
      chk_bit("sat undo clears sat", sat, 1'b0);
      tick(); chk_score("sat undo 98", 8'h98); chk_bit("sat undo busy", busy, 1'b0);

      // Clip at 99 again, then add from 99 records nothing to undo
      press(P2); run(2);
      chk_score("re 99", 8'h99); chk_bit("re sat", sat, 1'b1);
      press(P1); tick();
      chk_score("p1 at 99", 8'h99); chk_bit("p1 at 99 busy", busy, 1'b0);
      press(UNDO);
      chk_bit("undo after clip busy", busy, 1'b0);
      tick(); chk_score("undo after clip", 8'h99);
      press(CLR);
      chk_score("clr score", 8'h00); chk_bit("clr sat", sat, 1'b0);

      // Held p2 produces exactly one event
      drive(P2);
      run(10);
      chk_score("hold p2", 8'h02); chk_bit("hold p2 busy", busy, 1'b0);
      drive(5'b00000);
      tick();

      // p1 and p3 together: only +3
      press(P1 | P3); run(3);
      chk_score("p1+p3", 8'h05);

      // p1 during a busy add is dropped
      press(P3);
      drive(P1);
      tick();
      drive(5'b00000);
      run(3);
      chk_score("p1 while busy", 8'h08); chk_bit("p1 while busy idle", busy, 1'b0);

      // Clear during the second INC step of +3 from 50
      press(CLR);
      for (int i = 0; i < 16; i++) begin
         press(P3); run(3);
      end
      press(P2); run(2);
      chk_score("at 50", 8'h50);
      press(P3);
      tick(); chk_score("clr mid 51", 8'h51);
      press(CLR);
      chk_score("clr mid score", 8'h00); chk_bit("clr mid busy", busy, 1'b0);
      tick(); chk_score("clr mid stays", 8'h00);
      press(UNDO);
      chk_bit("undo after clr busy", busy, 1'b0);
      tick(); chk_score("undo after clr", 8'h00);

      // Asynchronous reset mid-INC, p1 held through release
      press(P3);
      tick(); tick();
      chk_score("pre reset 02", 8'h02);
      #2 rst_n = 1'b0;
      #1;
      chk_score("async reset score", 8'h00);
      chk_bit("async reset busy", busy, 1'b0);
      chk_bit("async reset sat", sat, 1'b0);
      drive(P1);
      run(2);
      rst_n = 1'b1;
      run(4);
      chk_score("held p1 through reset", 8'h00);
      chk_bit("held p1 busy", busy, 1'b0);
      drive(5'b00000);
      tick();
      press(P1); tick();
      chk_score("p1 after reset", 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/placar_bcd.md
# placar_bcd

Two-digit BCD score accumulator for one team on the basketball scoreboard. It turns debounced 1-, 2- and 3-point button presses, plus undo and clear commands, into a saturating 00–99 score. The score is presented as two 4-bit BCD digits, which feed directly into the digit-packing stage that builds the 8-bit display word (units in the low nibble, tens in the high nibble).

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  reset; asynchronous, active-low
- btn_p1  input  1  add 1 point; level, already debounced, synchronous to clk
- btn_p2  input  1  add 2 points; level, debounced, synchronous
- btn_p3  input  1  add 3 points; level, debounced, synchronous
- btn_undo  input  1  remove the points applied by the most recent addition
- btn_clr  input  1  clear the score to 00
- unidade  output  4  BCD units digit, 0–9
- dezena  output  4  BCD tens digit, 0–9
- busy  output  1  high while an add or undo sequence is in progress
- sat  output  1  high once an addition has been clipped at 99

## Operation
- **Edge detection:** each btn_* input has a prev register that resets to 1. An event is defined as btn & ~prev. Because prev resets to 1, a button held through reset produces no event, and a held button produces exactly one event.
- **States:** IDLE, INC, DEC.
- **Internal registers:**
  - pend (2 bits): steps remaining in the current sequence.
  - last (2 bits): points actually applied by the last addition.
- **Event priority in IDLE**, when several events occur in the same cycle: clr > undo > p3 > p2 > p1. Only the highest-priority event acts; the others are dropped.
- **Clear (any state, including INC/DEC):**
  - unidade = 0, dezena = 0, last = 0, pend = 0, sat = 0.
  - State goes to IDLE, aborting any sequence in progress.
- **Add n points (IDLE only):**
  - pend = n, last = 0, state goes to INC.
  - In INC, each cycle:
    - If the score is 99: sat = 1, pend = 0, state goes to IDLE. The score is unchanged.
    - Otherwise: BCD increment, last += 1, pend -= 1. When pend reaches 0, state goes to IDLE.
- **Undo (IDLE only):**
  - If last = 0, the undo is a no-op.
  - Otherwise: pend = last, last = 0, sat = 0, state goes to DEC.
  - In DEC, each cycle: BCD decrement, pend -= 1, and state goes to IDLE when pend reaches 0.
  - A second undo is therefore a no-op (single-level history).
- **BCD increment:** if unidade = 9, then unidade = 0 and dezena += 1; otherwise unidade += 1.
- **BCD decrement:** if unidade = 0, then unidade = 9 and dezena -= 1; otherwise unidade -= 1. The score never goes below 00, because undo only removes points that were actually applied.
- **Events while busy:** add and undo events arriving in INC/DEC are dropped, not queued. The prev registers keep tracking the inputs regardless of state.
- **Digit invariant:** unidade and dezena never hold values 10–15.

## Timing
- **Reset values** (rst_n low, asynchronous): unidade = 0, dezena = 0, busy = 0, sat = 0, state = IDLE, pend = 0, last = 0, all prev = 1.
- busy = (state != IDLE). It is registered, so it has no combinational path from the inputs.
- **Add latency:** the event is sampled at edge k, and busy is high after edge k. The score updates at edges k+1 … k+n, and busy falls at edge k+n. An add of n points therefore holds busy high for n cycles.
- **Saturation mid-add:** the sequence ends early. If the score reaches 99 after m < n steps, sat rises at edge k+m+1 and busy falls at that same edge.
- **Undo latency:** identical to an add of `last` points.
- **Clear latency:** outputs are 00 after the edge that samples the event. A clear in INC/DEC overrides that cycle's step.
- **Reset mid-sequence:** outputs return to reset values immediately. No sequence resumes after rst_n deasserts.

## Test plan
- From 00, pulse btn_p3 → busy high for 3 cycles, score 01, 02, 03; last = 3; sat = 0.
- From 08, btn_p3 → 09, 10, 11 (units wrap into tens); then btn_undo → 10, 09, 08; a second btn_undo → score stays 08.
- From 98, btn_p3 → 99, then sat = 1, busy falls after 2 cycles, last = 1; btn_undo → 98, sat = 0.
- Hold btn_p2 high for 10 cycles from 00 → score 02, exactly one event. Assert btn_p1 and btn_p3 in the same cycle → +3 only. btn_p1 pulsed while busy → ignored.
- btn_clr asserted during the second INC step of a +3 from 50 → score 00 on the next edge, busy = 0, last = 0; a following btn_undo → no change.
- rst_n low mid-INC → outputs 00, busy = 0, sat = 0 asynchronously. Hold btn_p1 high through reset release → no increment.
